// File: rtl/oam_dma.sv
// ---------------------------------------------------------------------------
// oam_dma -- NES sprite DMA engine ($4014)
//
// A CPU write to DMA_REG_ADDR halts the 6502 and copies the 256 bytes of page
// {V,00}-{V,FF} into OAM_DATA_ADDR, one read/write pair per byte.  Reads only
// happen in "get" cycles (phase 0), so the engine inserts a one-cycle dummy
// read when the halt lands on the wrong phase.  While the engine owns the bus
// it drives the address mux, rw and the data-bus mux select.
//
// Ports:
//   clk        in   system clock, one CPU cycle per rising edge
//   rst_n      in   asynchronous active-low reset
//   cpu_addr   in   CPU address for the current cycle
//   cpu_wdata  in   CPU write data for the current cycle
//   cpu_rw     in   CPU rw (1=read, 0=write)
//   bus_rdata  in   data bus contents, valid at the edge ending a read
//   rdy        out  1=CPU may advance, 0=CPU halted
//   bus_own    out  1=address mux selects addr_out
//   addr_out   out  DMA bus address
//   rw_out     out  DMA rw; follows cpu_rw whenever the bus is not owned
//   data_sel   out  data bus mux select
//   data_out   out  byte latched from the last DMA read
// ---------------------------------------------------------------------------
module oam_dma #(
   parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
   parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
   parameter logic [2:0]  DMA_DATA_SEL  = 3'd5,
   parameter logic [2:0]  CPU_DATA_SEL  = 3'd0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   input  logic        cpu_rw,
   input  logic [7:0]  bus_rdata,
   output logic        rdy,
   output logic        bus_own,
   output logic [15:0] addr_out,
   output logic        rw_out,
   output logic [2:0]  data_sel,
   output logic [7:0]  data_out
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_HALT  = 3'd1,
      S_ALIGN = 3'd2,
      S_READ  = 3'd3,
      S_WRITE = 3'd4
   } state_t;

   state_t      state_r;
   logic [7:0]  page_r;
   logic [7:0]  idx_r;
   logic        phase_r;
   logic [7:0]  data_out_r;
   logic        rdy_r;
   logic        bus_own_r;
   logic [15:0] addr_r;
   logic        rw_r;
   logic [2:0]  sel_r;

   logic        trigger_s;
   logic [7:0]  idx_inc_s;

   assign trigger_s = (cpu_rw == 1'b0) && (cpu_addr == DMA_REG_ADDR);
   // Wraps inside the page; never carries into page_r.
   assign idx_inc_s = idx_r + 8'd1;

   // Transfer FSM; every output register is loaded with the value for the
   // state being entered, so outputs depend only on registered state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= S_IDLE;
         page_r     <= 8'h00;
         idx_r      <= 8'h00;
         phase_r    <= 1'b0;
         data_out_r <= 8'h00;
         rdy_r      <= 1'b1;
         bus_own_r  <= 1'b0;
         addr_r     <= 16'h0000;
         rw_r       <= 1'b1;
         sel_r      <= CPU_DATA_SEL;
      end else begin
         // get/put phase runs freely from reset, independent of the FSM
         phase_r <= ~phase_r;
         case (state_r)
            S_IDLE: begin
               if (trigger_s) begin
                  state_r <= S_HALT;
                  page_r  <= cpu_wdata;
                  idx_r   <= 8'h00;
                  rdy_r   <= 1'b0;
               end else begin
                  state_r <= S_IDLE;
                  rdy_r   <= 1'b1;
               end
               bus_own_r <= 1'b0;
               addr_r    <= 16'h0000;
               rw_r      <= 1'b1;
               sel_r     <= CPU_DATA_SEL;
            end
            S_HALT: begin
               // A HALT in a get cycle means the next cycle is a put, which
               // cannot read: burn it as a dummy read to realign.
               if (phase_r == 1'b0) begin
                  state_r <= S_ALIGN;
               end else begin
                  state_r <= S_READ;
               end
               bus_own_r <= 1'b1;
               addr_r    <= {page_r, idx_r};
               rw_r      <= 1'b1;
               sel_r     <= CPU_DATA_SEL;
            end
            S_ALIGN: begin
               state_r   <= S_READ;
               bus_own_r <= 1'b1;
               addr_r    <= {page_r, idx_r};
               rw_r      <= 1'b1;
               sel_r     <= CPU_DATA_SEL;
            end
            S_READ: begin
               data_out_r <= bus_rdata;
               state_r    <= S_WRITE;
               bus_own_r  <= 1'b1;
               addr_r     <= OAM_DATA_ADDR;
               rw_r       <= 1'b0;
               sel_r      <= DMA_DATA_SEL;
            end
            S_WRITE: begin
               idx_r <= idx_inc_s;
               if (idx_r == 8'hFF) begin
                  state_r   <= S_IDLE;
                  rdy_r     <= 1'b1;
                  bus_own_r <= 1'b0;
                  addr_r    <= 16'h0000;
               end else begin
                  state_r   <= S_READ;
                  bus_own_r <= 1'b1;
                  addr_r    <= {page_r, idx_inc_s};
               end
               rw_r  <= 1'b1;
               sel_r <= CPU_DATA_SEL;
            end
            default: begin
               state_r   <= S_IDLE;
               rdy_r     <= 1'b1;
               bus_own_r <= 1'b0;
               addr_r    <= 16'h0000;
               rw_r      <= 1'b1;
               sel_r     <= CPU_DATA_SEL;
            end
         endcase
      end
   end

   assign rdy      = rdy_r;
   assign bus_own  = bus_own_r;
   assign addr_out = addr_r;
   // The only pass-through path: when not owning the bus, rw is the CPU's.
   assign rw_out   = bus_own_r ? rw_r : cpu_rw;
   assign data_sel = sel_r;
   assign data_out = data_out_r;

endmodule

// File: tb/tb_oam_dma.sv
// ---------------------------------------------------------------------------
// tb_oam_dma -- self-checking bench for oam_dma
//
// A 64 KiB memory model answers DMA reads.  For each transfer the bench builds
// the expected cycle-by-cycle bus activity from the transfer rules (halt,
// optional dummy read, then 256 read/write pairs) and compares the DUT
// against it mid-cycle.
// ---------------------------------------------------------------------------
module tb_oam_dma;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_rw;
   logic [7:0]  bus_rdata;
   logic        rdy;
   logic        bus_own;
   logic [15:0] addr_out;
   logic        rw_out;
   logic [2:0]  data_sel;
   logic [7:0]  data_out;

   logic [7:0]  mem [0:65535];
   logic        ph;
   int          vectors = 0;
   int          miscompares = 0;

   typedef struct {
      logic        own;
      logic [15:0] addr;
      logic        rw;
      logic [2:0]  sel;
      logic        is_write;
      logic [7:0]  data;
      int          widx;
   } rec_t;

   rec_t exp_q[$];

   oam_dma dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rw    (cpu_rw),
      .bus_rdata (bus_rdata),
      .rdy       (rdy),
      .bus_own   (bus_own),
      .addr_out  (addr_out),
      .rw_out    (rw_out),
      .data_sel  (data_sel),
      .data_out  (data_out)
   );

   always #5 clk = ~clk;

   // get/put phase reference: toggles every clock from reset
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) ph <= 1'b0;
      else        ph <= ~ph;
   end

   // memory answers whatever address the DMA presents for a read
   always @(negedge clk) begin
      bus_rdata = (bus_own && rw_out) ? mem[addr_out] : 8'($urandom);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic check_idle(input string tag);
      chk(tag, 32'({rdy, bus_own, rw_out, data_sel}),
               32'({1'b1, 1'b0, cpu_rw, 3'd0}));
   endtask

   // Random CPU activity that must never start a transfer.
   task automatic idle_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         case ($urandom_range(0, 3))
            0: begin cpu_rw = 1'b1; cpu_addr = 16'h4014; end
            1: begin cpu_rw = 1'b0; cpu_addr = 16'h4015; end
            2: begin cpu_rw = 1'b1; cpu_addr = 16'($urandom); end
            default: begin
               cpu_rw   = 1'b0;
               cpu_addr = 16'($urandom);
               if (cpu_addr == 16'h4014) cpu_addr = 16'h4013;
            end
         endcase
         cpu_wdata = 8'($urandom);
         @(negedge clk); #1;
         check_idle("idle");
      end
   endtask

   // Trigger a transfer from page pg in the current cycle and follow it.
   // inject_at: record index after which a stray $4014 write is issued.
   // reset_at:  write index at which rst_n is pulsed (-1 = never).
   task automatic run_transfer(input logic [7:0] pg, input int inject_at, input int reset_at);
      rec_t r;
      logic align;
      int   k;
      // trigger edge ending a put cycle puts HALT in a get cycle -> dummy read
      align     = ph;
      cpu_rw    = 1'b0;
      cpu_addr  = 16'h4014;
      cpu_wdata = pg;
      exp_q.delete();
      r = '{own: 1'b0, addr: 16'h0000, rw: 1'b1, sel: 3'd0, is_write: 1'b0, data: 8'h00, widx: -1};
      exp_q.push_back(r);
      if (align) begin
         r = '{own: 1'b1, addr: {pg, 8'h00}, rw: 1'b1, sel: 3'd0, is_write: 1'b0, data: 8'h00, widx: -1};
         exp_q.push_back(r);
      end
      for (int i = 0; i < 256; i++) begin
         r = '{own: 1'b1, addr: {pg, 8'(i)}, rw: 1'b1, sel: 3'd0, is_write: 1'b0, data: 8'h00, widx: -1};
         exp_q.push_back(r);
         r = '{own: 1'b1, addr: 16'h2004, rw: 1'b0, sel: 3'd5, is_write: 1'b1,
               data: mem[{pg, 8'(i)}], widx: i};
         exp_q.push_back(r);
      end
      k = 0;
      while (exp_q.size() > 0) begin
         r = exp_q.pop_front();
         @(negedge clk); #1;
         if (!r.own) begin
            chk("halt", 32'({rdy, bus_own, rw_out, data_sel}),
                        32'({1'b0, 1'b0, cpu_rw, r.sel}));
         end else begin
            chk("bus", 32'({rdy, bus_own, addr_out, rw_out, data_sel}),
                       32'({1'b0, 1'b1, r.addr, r.rw, r.sel}));
         end
         if (r.is_write) begin
            chk("data", 32'(data_out), 32'(r.data));
            if (r.widx == reset_at) begin
               rst_n = 1'b0;
               #1;
               chk("rst_mid", 32'({rdy, bus_own, data_out, data_sel}),
                              32'({1'b1, 1'b0, 8'h00, 3'd0}));
               #1;
               rst_n = 1'b1;
               cpu_rw = 1'b1;
               cpu_addr = 16'h0000;
               exp_q.delete();
               return;
            end
         end
         if (k == inject_at) begin
            cpu_rw = 1'b0; cpu_addr = 16'h4014; cpu_wdata = 8'h55;
         end else begin
            cpu_rw = 1'b1; cpu_addr = 16'($urandom); cpu_wdata = 8'($urandom);
         end
         k++;
      end
      // one cycle after the final write the CPU is released
      @(negedge clk); #1;
      check_idle("done");
   endtask

   initial begin
      logic [7:0] pg;
      for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
      for (int i = 0; i < 256; i++) mem[16'hFF00 + i] = ~8'(i);

      rst_n = 1'b0; cpu_rw = 1'b1; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
      repeat (3) @(negedge clk);
      #1;
      chk("reset", 32'({rdy, bus_own, data_sel, data_out, rw_out}),
                   32'({1'b1, 1'b0, 3'd0, 8'h00, cpu_rw}));
      rst_n = 1'b1;

      // reads of $4014 and writes of $4015 must not trigger
      idle_cycles(12);

      // trigger edge at phase 0: 513-cycle halt
      if (ph) idle_cycles(1);
      run_transfer(8'h02, -1, -1);

      // trigger edge at phase 1: dummy read, 514-cycle halt
      if (!ph) idle_cycles(1);
      run_transfer(8'h02, -1, -1);

      // last page, inverted pattern; addresses must stay within page FF
      idle_cycles($urandom_range(1, 4));
      run_transfer(8'hFF, -1, -1);

      // back-to-back: trigger in the first idle cycle after the last write
      run_transfer(8'($urandom), -1, -1);

      // stray $4014 write mid-transfer is ignored
      idle_cycles(2);
      pg = 8'($urandom);
      if (pg == 8'h55) pg = 8'h56;
      run_transfer(pg, $urandom_range(1, 500), -1);

      // reset at the 100th write, then no further bus activity
      idle_cycles($urandom_range(1, 3));
      run_transfer(8'($urandom), -1, 99);
      idle_cycles(20);

      // engine recovers after the reset
      run_transfer(8'($urandom), -1, -1);
      idle_cycles(4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
